ram_cache_burst: RTL
====================

// Module: ram_cache_burst
// PURPOSE
//  Parametrised single-clock sample cache between the USB3 slave-FIFO reader and the DA output path.
//  Stores words while the USB reader asserts wr_en. On each falling edge of the FX3 flag (trig_n) it emits one
//  fixed-length burst of buffered words with a valid strobe.
//  Adds full/empty/level reporting and sticky overflow/underflow status.
// PARAMETERS
//  DATA_W     32   word width
//  ADDR_W     8    RAM address width; DEPTH = 2**ADDR_W words
//  BURST_LEN  256  words per burst; legal range 1..DEPTH (elaboration error otherwise)
// PORTS
//  clock      in   1         sole clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  wr_data    in   DATA_W    write word
//  wr_en      in   1         write request, one word per cycle
//  trig_n     in   1         FX3 FLAGA, asynchronous; a falling edge requests one burst
//  clr_flags  in   1         synchronous clear of overflow/underflow
//  loop_mode  in   1         present only with RAM_CACHE_LOOP_EN
//  rd_data    out  DATA_W    burst word
//  rd_valid   out  1         rd_data valid this cycle
//  busy       out  1         burst in progress
//  level      out  ADDR_W+1  stored word count, 0..DEPTH
//  full       out  1         level==DEPTH
//  empty      out  1         level==0
//  overflow   out  1         sticky: a write was dropped
//  underflow  out  1         sticky: a burst was refused
// BEHAVIOUR
//  Reset:
//   - Pointers, level, rd_data, rd_valid, busy, overflow, underflow = 0; empty=1; full=0.
//   - Sync flops = 1; FSM = IDLE.
//   - Reset takes effect immediately, including mid-burst.
//  Pointers: wp and rp are ADDR_W+1 bits and wrap modulo 2*DEPTH. level = wp-rp. full and empty are registered
//   from the next-state level.
//  Write: wr_en & ~full writes mem[wp[ADDR_W-1:0]] and does wp++. wr_en & full drops the word and sets overflow.
//  Trigger path:
//   - trig_n passes through 2 flops (s1,s2), then a third flop s3.
//   - trig_pulse = s3 & ~s2.
//   - A held-low trig_n gives exactly one pulse.
//  FSM IDLE:
//   - trig_pulse & level>=BURST_LEN: go to BURST and load cnt=BURST_LEN-1.
//   - trig_pulse & level<BURST_LEN: set underflow, stay in IDLE, no reads.
//  FSM BURST:
//   - Reads one word per cycle at rp and does rp++ each cycle.
//   - cnt decrements; cnt==0 returns the FSM to IDLE.
//   - busy=1 throughout BURST.
//   - trig_pulse during BURST is ignored: no queueing, no flag.
//  Read latency: RAM read is registered, so rd_valid = read issued one cycle earlier.
//   - rd_valid is high for exactly BURST_LEN consecutive cycles.
//   - rd_data holds its last value between bursts.
//  Simultaneous write and read: both pointers advance and level is unchanged.
//   - A word written in the same cycle it becomes readable is never read in that cycle. Sufficiency is checked
//     at burst start, so the FIFO cannot underrun mid-burst.
//  Status flags: clr_flags clears both flags. A set event in the same cycle wins over clr_flags.
// CONFIGURATION
//  RAM_CACHE_LOOP_EN defined:
//   - loop_mode is sampled on entry to BURST.
//   - If 1, rp is saved at burst start and restored when the burst ends. The burst is replayed without consuming
//     data and level returns to its pre-burst value.
//   - Writes are still accepted while level<DEPTH. The BURST_LEN sufficiency check still applies.
//  RAM_CACHE_LOOP_EN undefined: the loop_mode port and rewind logic are absent, and every burst consumes.
// STRUCTURE
//  Package ram_cache_pkg:
//   - rc_state_t enum {RC_IDLE, RC_BURST}.
//   - Default-parameter localparams.
//   - Function rc_level(wp,rp).
//  Sub-module ram_cache_dpram: single-clock simple dual-port RAM, registered read, no reset on the array.
//  Top-level owns pointers, sync chain, FSM and flags.
// TESTING
//  Default parameters throughout. Tstart = first rising edge that samples trig_n low.
//  1 Write 0..255 on consecutive cycles -> full=1 after the 256th word, level=256. A 257th write -> dropped,
//    overflow=1, level=256.
//  2 From state 1, drop trig_n -> first rd_valid 4 edges after Tstart, counting Tstart as edge 1.
//    -> rd_data 0..255 in order, rd_valid high 256 cycles, then level=0, empty=1, busy=0.
//  3 Write 100 words, pulse trig_n -> no rd_valid, underflow=1, level=100. Then clr_flags=1 -> underflow=0.
//  4 Preload 256 words, trigger, write 0x1000+i every burst cycle -> level stays 256.
//    -> Burst output is the original data, a second burst yields 0x1000.., and the pointers wrap cleanly.
//  5 Assert rst_n low at burst word 37 -> rd_valid=0, busy=0, level=0 asynchronously. Later triggers obey rule 3.
//  6 With RAM_CACHE_LOOP_EN and loop_mode=1, two triggers on 256 words -> identical 0..255 sequences, level=256
//    after each burst.

Source files
------------

// File: rtl/ram_cache_pkg.sv
// Shared types, default parameters and level helper for the ram_cache_burst sample cache.
// Optional replay feature is controlled by RAM_CACHE_LOOP_EN (see ram_cache_burst).
package ram_cache_pkg;

  localparam int unsigned RC_DATA_W    = 32;
  localparam int unsigned RC_ADDR_W    = 8;
  localparam int unsigned RC_BURST_LEN = 256;

  typedef enum logic [0:0] {
    RC_IDLE,
    RC_BURST
  } rc_state_t;

  // Pointers are addr_w+1 bits wide; the difference wraps modulo 2*DEPTH.
  function automatic logic [31:0] rc_level(input logic [31:0] wp, input logic [31:0] rp,
                                           input int unsigned addr_w);
    logic [31:0] mask;
    mask = (32'd1 << (addr_w + 32'd1)) - 32'd1;
    return (wp - rp) & mask;
  endfunction

endpackage

// File: rtl/ram_cache_burst_if.sv
// Write, trigger, burst-read and status signals of the ram_cache_burst sample cache.
// loop_mode exists only when RAM_CACHE_LOOP_EN is defined.
interface ram_cache_burst_if #(
  parameter int unsigned DATA_W = ram_cache_pkg::RC_DATA_W,
  parameter int unsigned ADDR_W = ram_cache_pkg::RC_ADDR_W
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              trig_n;
  logic              clr_flags;
`ifdef RAM_CACHE_LOOP_EN
  logic              loop_mode;
`endif
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_data, wr_en, trig_n, clr_flags,
`ifdef RAM_CACHE_LOOP_EN
    output loop_mode,
`endif
    input  rd_data, rd_valid, busy, level, full, empty, overflow, underflow
  );

  modport slave (
    input  wr_data, wr_en, trig_n, clr_flags,
`ifdef RAM_CACHE_LOOP_EN
    input  loop_mode,
`endif
    output rd_data, rd_valid, busy, level, full, empty, overflow, underflow
  );
endinterface

// File: rtl/ram_cache_dpram.sv
// Single-clock simple dual-port RAM with registered read; the array itself is not reset.
module ram_cache_dpram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address write and read returns the old word; rdata holds between reads.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_cache_burst.sv
// Sample cache: buffers USB words and emits one fixed-length burst per falling edge of trig_n.
// Define RAM_CACHE_LOOP_EN to add loop_mode (replay a burst without consuming it).
module ram_cache_burst
  import ram_cache_pkg::*;
#(
  parameter int unsigned DATA_W    = RC_DATA_W,
  parameter int unsigned ADDR_W    = RC_ADDR_W,
  parameter int unsigned BURST_LEN = RC_BURST_LEN
) (
  input logic              clock,
  input logic              rst_n,
  ram_cache_burst_if.slave bus
);

  localparam int unsigned     DEPTH    = 2 ** ADDR_W;
  localparam int unsigned     PW       = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_L  = PW'(DEPTH);
  localparam logic [ADDR_W:0] BURST_L  = PW'(BURST_LEN);
  localparam logic [ADDR_W-1:0] CNT_INIT = ADDR_W'(BURST_LEN - 1);

  if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst_len
    $error("ram_cache_burst: BURST_LEN must be in 1..2**ADDR_W");
  end

  rc_state_t         state_q, state_d;
  logic [ADDR_W:0]   wp_q, wp_d, rp_q, rp_d, level_q, level_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              full_q, empty_q;
  logic              s1_q, s2_q, s3_q, trig_pulse;
  logic              rd_valid_q, overflow_q, underflow_q;
  logic              re, wr_ok, ovf_set, unf_set;
`ifdef RAM_CACHE_LOOP_EN
  logic              loop_q, loop_d;
  logic [ADDR_W:0]   rp_save_q, rp_save_d, keep;
  logic              room;
`endif

  assign trig_pulse = s3_q & ~s2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rp_d    = rp_q;
    re      = 1'b0;
    unf_set = 1'b0;
`ifdef RAM_CACHE_LOOP_EN
    loop_d    = loop_q;
    rp_save_d = rp_save_q;
`endif
    case (state_q)
      RC_IDLE: begin
        if (trig_pulse) begin
          if (level_q >= BURST_L) begin
            state_d = RC_BURST;
            cnt_d   = CNT_INIT;
`ifdef RAM_CACHE_LOOP_EN
            loop_d    = bus.loop_mode;
            rp_save_d = rp_q;
`endif
          end else begin
            unf_set = 1'b1;
          end
        end
      end
      RC_BURST: begin
        re    = 1'b1;
        rp_d  = rp_q + 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = RC_IDLE;
`ifdef RAM_CACHE_LOOP_EN
          if (loop_q) rp_d = rp_save_q;
`endif
        end
      end
      default: state_d = RC_IDLE;
    endcase

    // A consuming read frees a slot in the same cycle, so a write into a full cache is kept.
`ifdef RAM_CACHE_LOOP_EN
    keep  = (state_q == RC_BURST && loop_q) ? rp_save_q : rp_q;
    room  = PW'(rc_level(32'(wp_q), 32'(keep), ADDR_W)) < DEPTH_L;
    wr_ok = bus.wr_en & (room | (re & ~loop_q));
`else
    wr_ok = bus.wr_en & (~full_q | re);
`endif
    ovf_set = bus.wr_en & ~wr_ok;
    wp_d    = wp_q + {{ADDR_W{1'b0}}, wr_ok};
    level_d = PW'(rc_level(32'(wp_d), 32'(rp_d), ADDR_W));
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RC_IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      s3_q        <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef RAM_CACHE_LOOP_EN
      loop_q      <= 1'b0;
      rp_save_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      full_q      <= (level_d == DEPTH_L);
      empty_q     <= (level_d == '0);
      s1_q        <= bus.trig_n;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      rd_valid_q  <= re;
      overflow_q  <= ovf_set | (overflow_q & ~bus.clr_flags);
      underflow_q <= unf_set | (underflow_q & ~bus.clr_flags);
`ifdef RAM_CACHE_LOOP_EN
      loop_q      <= loop_d;
      rp_save_q   <= rp_save_d;
`endif
    end
  end

  ram_cache_dpram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock(clock),
    .rst_n(rst_n),
    .we   (wr_ok),
    .waddr(wp_q[ADDR_W-1:0]),
    .wdata(bus.wr_data),
    .re   (re),
    .raddr(rp_q[ADDR_W-1:0]),
    .rdata(bus.rd_data)
  );

  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = (state_q == RC_BURST);
  assign bus.level     = level_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule
